// File: rtl/pixel_row_packer.sv
// -----------------------------------------------------------------------------
// pixel_row_packer
//
// Upstream feeder for input_shift_reg in the subpixel interpolation datapath.
// Accepts reference pixels one per cycle in raster order over valid/ready,
// packs each group of ROW_PIX pixels into one row (column 0 in the LSB byte),
// and presents the row with an active-low load strobe that the downstream
// shift register samples on the falling clock edge. ROWS rows make one
// reference block; block_done pulses when the final row of a block loads.
//
// Optional feature (macro PIXEL_ROW_PAD_EN): picture-edge padding. Adds input
// pix_eol; a pixel accepted with pix_eol=1 at column c fills columns c..ROW_PIX-1
// and completes the row on that edge.
//
// Ports:
//   clock       in   rising-edge clock
//   reset       in   asynchronous, active-high reset
//   pix_in      in   incoming pixel (PIX_W)
//   pix_valid   in   pix_in valid
//   pix_ready   out  packer can accept pix_in this cycle
//   abort       in   synchronous block abort (highest priority)
//   stall       in   downstream must not load this cycle
//   pix_eol     in   end-of-line padding request (PIXEL_ROW_PAD_EN only)
//   row_out     out  packed row, registered (PIX_W*ROW_PIX)
//   load_L      out  active-low row load strobe for downstream
//   row_idx     out  index 0..ROWS-1 of the row in row_out
//   block_busy  out  a block is in progress
//   block_done  out  one-cycle pulse when the final row loads
// -----------------------------------------------------------------------------
module pixel_row_packer #(
   parameter int PIX_W   = 8,
   parameter int ROW_PIX = 15,
   parameter int ROWS    = 15
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic [PIX_W-1:0]         pix_in,
   input  logic                     pix_valid,
   output logic                     pix_ready,
   input  logic                     abort,
   input  logic                     stall,
`ifdef PIXEL_ROW_PAD_EN
   input  logic                     pix_eol,
`endif
   output logic [PIX_W*ROW_PIX-1:0] row_out,
   output logic                     load_L,
   output logic [3:0]               row_idx,
   output logic                     block_busy,
   output logic                     block_done
);

   localparam int                 COL_W    = $clog2(ROW_PIX);
   localparam int                 ROW_W    = PIX_W * ROW_PIX;
   localparam int                 ASM_W    = PIX_W * (ROW_PIX - 1);
   localparam logic [COL_W-1:0]   LAST_COL = COL_W'(ROW_PIX - 1);
   localparam logic [3:0]         LAST_ROW = 4'(ROWS - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_FILL,
      S_LAST
   } state_t;

   state_t             r_state;
   state_t             w_state_nxt;

   logic [COL_W-1:0]   r_col;
   logic [3:0]         r_row_cnt;
   logic [3:0]         r_row_idx;
   logic               r_hold_full;
   logic [ROW_W-1:0]   r_row_out;
   logic [ASM_W-1:0]   r_asm;

   logic               w_eol;
   logic               w_row_end;
   logic               w_load;
   logic               w_accept;
   logic               w_row_wr;
   logic [ROW_W-1:0]   w_row_new;

`ifdef PIXEL_ROW_PAD_EN
   assign w_eol = pix_eol;
`else
   assign w_eol = 1'b0;
`endif

   // The accepted pixel closes the row: either the last column or a padded
   // end-of-line (pix_eol at the last column behaves like a plain last column).
   assign w_row_end = (r_col == LAST_COL) | w_eol;

   // --------------------------------------------------------------------------
   // FSM next state and handshake outputs
   // --------------------------------------------------------------------------
   // NOTE: every output of a combinational block gets a default first so no
   // path leaves it unassigned, which would otherwise infer a latch.
   always_comb begin
      w_state_nxt = r_state;
      w_load      = r_hold_full & ~stall;
      load_L      = ~w_load;
      // Only the row-closing pixel can be back-pressured, and only when the
      // holding register is full and cannot drain this cycle.
      pix_ready   = (r_state != S_LAST) & (~w_row_end | ~r_hold_full | ~stall);
      w_accept    = pix_valid & pix_ready;
      w_row_wr    = w_accept & w_row_end & ~abort;
      block_busy  = (r_state != S_IDLE);
      block_done  = (r_state == S_LAST) & w_load & (r_row_idx == LAST_ROW);

      case (r_state)
         S_IDLE: begin
            if (w_row_wr && (r_row_cnt == LAST_ROW)) w_state_nxt = S_LAST;
            else if (w_accept)                       w_state_nxt = S_FILL;
         end
         S_FILL: begin
            if (w_row_wr && (r_row_cnt == LAST_ROW)) w_state_nxt = S_LAST;
         end
         S_LAST: begin
            if (block_done) w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase

      if (abort) w_state_nxt = S_IDLE;
   end

   // NOTE: clocked state uses non-blocking assignments so every register
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_state_nxt;
   end

   // --------------------------------------------------------------------------
   // New row: columns below the current one come from the assembly register,
   // the current column and everything above it take pix_in. Without padding
   // a row is only written at the last column, so this reduces to
   // {pix_in, r_asm}.
   // --------------------------------------------------------------------------
   always_comb begin
      w_row_new = '0;
      for (int c = 0; c < ROW_PIX - 1; c++) begin
         w_row_new[c*PIX_W +: PIX_W] = (COL_W'(c) >= r_col) ? pix_in
                                                            : r_asm[c*PIX_W +: PIX_W];
      end
      w_row_new[(ROW_PIX-1)*PIX_W +: PIX_W] = pix_in;
   end

   // NOTE: the assembly register has no reset; every column is written in the
   // current row before it is ever read into a completed row.
   always_ff @(posedge clock) begin
      if (w_accept && !abort && !w_row_end) begin
         for (int c = 0; c < ROW_PIX - 1; c++) begin
            if (r_col == COL_W'(c)) r_asm[c*PIX_W +: PIX_W] <= pix_in;
         end
      end
   end

   // --------------------------------------------------------------------------
   // Column / row counters and the holding register
   // --------------------------------------------------------------------------
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_col       <= '0;
         r_row_cnt   <= '0;
         r_row_idx   <= '0;
         r_hold_full <= 1'b0;
         r_row_out   <= '0;
      end else if (abort) begin
         // row_out is deliberately retained across an abort.
         r_col       <= '0;
         r_row_cnt   <= '0;
         r_row_idx   <= '0;
         r_hold_full <= 1'b0;
      end else begin
         if (w_accept) r_col <= w_row_end ? '0 : r_col + COL_W'(1);

         // A write in the same cycle as a load keeps hold_full set: the old
         // row leaves on the falling edge, the new one arrives on the rising.
         if (w_row_wr) begin
            r_row_out   <= w_row_new;
            r_row_idx   <= r_row_cnt;
            r_row_cnt   <= (r_row_cnt == LAST_ROW) ? 4'd0 : r_row_cnt + 4'd1;
            r_hold_full <= 1'b1;
         end else if (w_load) begin
            r_hold_full <= 1'b0;
         end

         if ((r_state == S_LAST) && (w_state_nxt == S_IDLE)) begin
            r_row_cnt <= '0;
            r_row_idx <= '0;
         end
      end
   end

   assign row_out = r_row_out;
   assign row_idx = r_row_idx;

endmodule

// File: tb/tb_pixel_row_packer.sv
// -----------------------------------------------------------------------------
// tb_pixel_row_packer
//
// Directed bench for pixel_row_packer. A byte-level model builds each expected
// row when its closing pixel is accepted and pushes it to a scoreboard queue;
// a falling-edge monitor pops and compares whenever load_L is low.
// Define PIXEL_ROW_PAD_EN to exercise the padding feature.
// -----------------------------------------------------------------------------
module tb_pixel_row_packer;

   localparam int PIX_W   = 8;
   localparam int ROW_PIX = 15;
   localparam int ROWS    = 15;
   localparam int ROW_W   = PIX_W * ROW_PIX;

   logic             clock = 1'b0;
   logic             reset;
   logic [PIX_W-1:0] pix_in;
   logic             pix_valid;
   logic             pix_ready;
   logic             abort;
   logic             stall;
   logic             pix_eol;
   logic [ROW_W-1:0] row_out;
   logic             load_L;
   logic [3:0]       row_idx;
   logic             block_busy;
   logic             block_done;

   always #5 clock = ~clock;

   pixel_row_packer #(.PIX_W(PIX_W), .ROW_PIX(ROW_PIX), .ROWS(ROWS)) dut (
      .clock      (clock),
      .reset      (reset),
      .pix_in     (pix_in),
      .pix_valid  (pix_valid),
      .pix_ready  (pix_ready),
      .abort      (abort),
      .stall      (stall),
`ifdef PIXEL_ROW_PAD_EN
      .pix_eol    (pix_eol),
`endif
      .row_out    (row_out),
      .load_L     (load_L),
      .row_idx    (row_idx),
      .block_busy (block_busy),
      .block_done (block_done)
   );

   // ---------------------------------------------------------------- checking
   int n_checks = 0;
   int n_pass   = 0;
   int n_fail   = 0;

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // ---------------------------------------------------------------- model
   typedef struct packed {
      logic [ROW_W-1:0] row;
      logic [3:0]       idx;
   } exp_t;

   exp_t       exp_q[$];
   logic [7:0] m_row [ROW_PIX];
   int         m_col    = 0;
   int         m_rowcnt = 0;

   task automatic model_accept(input logic [7:0] v, input logic eol);
      logic             fin;
      logic [ROW_W-1:0] r;
      exp_t             e;
      m_row[m_col] = v;
      fin = (m_col == ROW_PIX - 1);
`ifdef PIXEL_ROW_PAD_EN
      if (eol) begin
         for (int c = m_col; c < ROW_PIX; c++) m_row[c] = v;
         fin = 1'b1;
      end
`endif
      if (fin) begin
         r = '0;
         for (int c = 0; c < ROW_PIX; c++) r[c*PIX_W +: PIX_W] = m_row[c];
         e.row = r;
         e.idx = 4'(m_rowcnt);
         exp_q.push_back(e);
         m_rowcnt = (m_rowcnt + 1) % ROWS;
         m_col    = 0;
      end else begin
         m_col++;
      end
   endtask

   task automatic model_clear();
      m_col    = 0;
      m_rowcnt = 0;
   endtask

   // ---------------------------------------------------------------- monitor
   int               cyc     = 0;
   int               n_loads = 0;
   int               load_cyc[$];
   logic [ROW_W-1:0] last_loaded_row = '0;
   exp_t             mon_e;

   always @(posedge clock) cyc++;

   always @(negedge clock) begin
      if (load_L === 1'b0) begin
         n_loads++;
         load_cyc.push_back(cyc);
         check("load_has_expected_row", 128'(exp_q.size() > 0), 128'd1);
         if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            last_loaded_row = mon_e.row;
            check("row_out", 128'(row_out), 128'(mon_e.row));
            check("row_idx", 128'(row_idx), 128'(mon_e.idx));
            check("block_done_at_load", 128'(block_done), 128'(mon_e.idx == 4'(ROWS - 1)));
         end
      end
   end

   // ---------------------------------------------------------------- drivers
   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clock);
         #1;
      end
   endtask

   // Presents one pixel and holds it until accepted (bounded wait).
   task automatic send_pix(input logic [7:0] v, input logic eol = 1'b0);
      int guard;
      guard     = 0;
      pix_in    = v;
      pix_eol   = eol;
      pix_valid = 1'b1;
      @(negedge clock);
      while (!pix_ready && guard < 100) begin
         guard++;
         @(negedge clock);
      end
      if (guard >= 100) check("pix_ready_timeout", 128'(pix_ready), 128'd1);
      else              model_accept(v, eol);
      @(posedge clock);
      #1;
      pix_valid = 1'b0;
      pix_eol   = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog expired");
   end

   // ---------------------------------------------------------------- stimulus
   initial begin
      int l;

      // 1. Reset state, then idle with no valid pixels.
      reset = 1'b1; pix_valid = 1'b0; pix_in = '0; pix_eol = 1'b0;
      abort = 1'b0; stall = 1'b0;
      tick(2);
      @(negedge clock);
      check("rst_row_out",    128'(row_out),    128'd0);
      check("rst_load_L",     128'(load_L),     128'd1);
      check("rst_row_idx",    128'(row_idx),    128'd0);
      check("rst_block_busy", 128'(block_busy), 128'd0);
      check("rst_block_done", 128'(block_done), 128'd0);
      check("rst_pix_ready",  128'(pix_ready),  128'd1);
      @(posedge clock); #1;
      reset = 1'b0;
      l = n_loads;
      tick(10);
      check("idle_no_load", 128'(n_loads), 128'(l));

      // 2. Full block, no stall.
      load_cyc.delete();
      l = n_loads;
      for (int k = 0; k < ROWS * ROW_PIX; k++) begin
         send_pix(8'(k));
         if (k == 0) check("busy_after_first_pix", 128'(block_busy), 128'd1);
      end
      tick(3);
      check("blk_load_count", 128'(n_loads - l), 128'(ROWS));
      for (int i = 1; i < load_cyc.size(); i++)
         check("blk_load_spacing", 128'(load_cyc[i] - load_cyc[i-1]), 128'(ROW_PIX));
      check("blk_busy_cleared", 128'(block_busy), 128'd0);

      // 3. Stall while row 3 is held; row 4 columns 0..13 still accepted.
      for (int k = 0; k < 4 * ROW_PIX; k++) send_pix(8'(k * 7 + 3));
      stall = 1'b1;
      l = n_loads;
      for (int k = 4 * ROW_PIX; k < 5 * ROW_PIX - 1; k++) send_pix(8'(k * 7 + 3));
      pix_in    = 8'((5 * ROW_PIX - 1) * 7 + 3);
      pix_valid = 1'b1;
      @(negedge clock);
      check("stall_col14_not_ready", 128'(pix_ready), 128'd0);
      check("stall_load_L_high",     128'(load_L),    128'd1);
      check("stall_no_load",         128'(n_loads),   128'(l));
      @(posedge clock); #1;
      stall = 1'b0;
      for (int k = 5 * ROW_PIX - 1; k < ROWS * ROW_PIX; k++) send_pix(8'(k * 7 + 3));

      // 4. Stall in LAST for 5 cycles with a pixel offered.
      stall     = 1'b1;
      pix_in    = 8'h55;
      pix_valid = 1'b1;
      repeat (5) begin
         @(negedge clock);
         check("last_pix_ready",  128'(pix_ready),  128'd0);
         check("last_block_done", 128'(block_done), 128'd0);
         check("last_load_L",     128'(load_L),     128'd1);
         @(posedge clock); #1;
      end
      stall     = 1'b0;
      pix_valid = 1'b0;
      @(negedge clock);
      check("final_load_L",     128'(load_L),     128'd0);
      check("final_block_done", 128'(block_done), 128'd1);
      @(posedge clock); #1;
      check("final_busy_low",   128'(block_busy), 128'd0);
      check("final_pix_ready",  128'(pix_ready),  128'd1);

      // 5. Abort after 100 pixels, then a fresh block.
      for (int k = 0; k < 100; k++) send_pix(8'(k) ^ 8'h5A);
      abort     = 1'b1;
      pix_in    = 8'hEE;
      pix_valid = 1'b1;
      @(posedge clock); #1;
      abort     = 1'b0;
      pix_valid = 1'b0;
      model_clear();
      check("abort_rows_drained", 128'(exp_q.size()),  128'd0);
      check("abort_busy_low",     128'(block_busy),    128'd0);
      check("abort_pix_ready",    128'(pix_ready),     128'd1);
      check("abort_row_kept",     128'(row_out),       128'(last_loaded_row));
      l = n_loads;
      tick(20);
      check("abort_no_load", 128'(n_loads), 128'(l));
      for (int k = 0; k < ROWS * ROW_PIX; k++) send_pix(8'(k + 8'h40));
      tick(3);
      check("post_abort_busy_low", 128'(block_busy), 128'd0);

`ifdef PIXEL_ROW_PAD_EN
      // 6. Padding: end-of-line at column 9.
      for (int k = 0; k < 9; k++) send_pix(8'(k + 1));
      send_pix(8'hAB, 1'b1);
      @(negedge clock);
      check("pad_load_L",    128'(load_L),                128'd0);
      check("pad_bytes_hi",  128'(row_out[ROW_W-1:72]),   128'({6{8'hAB}}));
      @(posedge clock); #1;
      for (int k = 0; k < ROW_PIX; k++) send_pix(8'(k + 8'h10));
      tick(2);
      abort = 1'b1;
      tick(1);
      abort = 1'b0;
      model_clear();
      check("pad_rows_drained", 128'(exp_q.size()), 128'd0);
`endif

      // Reset mid-block with a stalled row held: load_L must stay high.
      tick(2);
      stall = 1'b1;
      for (int k = 0; k < ROW_PIX; k++) send_pix(8'(k + 8'h80));
      check("held_load_L",     128'(load_L),     128'd1);
      check("held_block_busy", 128'(block_busy), 128'd1);
      reset = 1'b1;
      stall = 1'b0;
      #1;
      check("midrst_load_L",     128'(load_L),     128'd1);
      check("midrst_block_busy", 128'(block_busy), 128'd0);
      check("midrst_row_out",    128'(row_out),    128'd0);
      check("midrst_row_idx",    128'(row_idx),    128'd0);
      check("midrst_pix_ready",  128'(pix_ready),  128'd1);
      exp_q.delete();
      model_clear();
      @(posedge clock); #1;
      reset = 1'b0;
      tick(3);
      check("scoreboard_drained", 128'(exp_q.size()), 128'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/pixel_row_packer.md
Name: pixel_row_packer

Overview:
Upstream feeder for input_shift_reg in the subpixel interpolation datapath. Accepts reference pixels one per cycle in raster order over a valid/ready handshake. Packs each group of 15 pixels into a 120-bit row and presents it with an active-low load strobe, which the shift register samples on the falling clock edge. Counts 15 rows per 15x15 reference block and flags block completion.

Parameters:
PIX_W, 8, bits per pixel
ROW_PIX, 15, pixels per row (row width = PIX_W*ROW_PIX = 120)
ROWS, 15, rows per reference block

Ports:
clock  in  1  rising-edge clock
reset  in  1  asynchronous, active-high reset
pix_in  in  PIX_W  incoming pixel
pix_valid  in  1  pix_in valid
pix_ready  out  1  packer can accept pix_in this cycle
abort  in  1  synchronous block abort
stall  in  1  downstream must not load this cycle
row_out  out  PIX_W*ROW_PIX  packed row, registered
load_L  out  1  active-low row load strobe for downstream
row_idx  out  4  index 0..ROWS-1 of the row in row_out
block_busy  out  1  a block is in progress
block_done  out  1  one-cycle pulse when the final row loads

Behaviour:
- Accept: a pixel is accepted at a rising edge when pix_valid & pix_ready are both high.
- Packing: accepted pixel at column c (0..14) goes to bits [c*8 +: 8]. Column 0 is the LSB byte.
- Column counter col wraps 14 -> 0.
- Assembly register holds columns 0..13.
- Holding register: on the edge that accepts column 14, {pix_in, assembly[111:0]} is written to row_out, and hold_full and row_idx are set. The row is visible the next cycle (1-cycle latency from last pixel).
- load_L = ~(hold_full & ~stall), combinational from registered hold_full and the stall input. It is stable before the falling edge.
- A row is consumed in any cycle with load_L low. hold_full clears at the following rising edge unless a new row is written at that same edge, in which case hold_full stays 1.
- pix_ready = (state != LAST) & ((col != 14) | ~hold_full | ~stall). Columns 0..13 are never back-pressured except in LAST.
- FSM states:
  - IDLE: col=0, block_busy=0. The first accepted pixel moves to FILL and sets block_busy.
  - FILL: the edge accepting column 14 of row ROWS-1 moves to LAST.
  - LAST: pix_ready=0. When the final row loads (load_L low, row_idx=ROWS-1), block_done=1 for that cycle (combinational) and the next edge moves to IDLE with block_busy=0.
- row_idx: row counter 0..ROWS-1. It is copied into row_idx when a row is written to the holding register and resets to 0 on return to IDLE.
- abort, synchronous and highest priority:
  - Next edge: state=IDLE, col=0, row counter=0, hold_full=0, block_busy=0.
  - row_out is retained.
  - A pixel presented in the abort cycle is dropped.
  - No load occurs in the abort cycle if stall is high.
- Reset values: state=IDLE, col=0, row_out=0, row_idx=0, hold_full=0, load_L=1, block_busy=0, block_done=0, pix_ready=1.
- Reset asserted mid-block clears everything immediately. The downstream sees load_L rise the same cycle.
- Simultaneous load and write in the same cycle: the old row loads at the falling edge, the new row is written at the next rising edge, and there is no bubble. Sustained throughput is 1 pixel per clock.

Optional Feature:
Macro PIXEL_ROW_PAD_EN enables picture-edge padding.
- With the macro: adds input port pix_eol (1 bit).
  - If a pixel is accepted with pix_eol=1 at column c<14, columns c..14 are all filled with that pixel.
  - The row completes on that edge exactly as if column 14 had been accepted, and col returns to 0.
  - pix_ready uses (col==14 | pix_eol) in place of (col==14).
  - pix_eol at column 14 has no extra effect.
- Without the macro: the port is absent and every row takes exactly ROW_PIX pixels.

Test Plan:
1. Reset check: assert reset -> row_out=0, load_L=1, row_idx=0, block_busy=0, block_done=0, pix_ready=1. Release, then drive pix_valid=0 for 10 cycles -> no load_L pulse.
2. Full block, no stall: 225 pixels of value k mod 256 -> 15 single-cycle load_L pulses 15 cycles apart. First row_out[7:0]=0x00 and [119:112]=0x0E. row_idx steps 0..14. block_done pulses with the 15th load, then block_busy falls.
3. Stall mid-block: stall=1 while row 3 is held and pixels continue -> columns 0..13 of row 4 accepted, pix_ready=0 at column 14, load_L=1. Release stall -> row 3 loads, next edge writes row 4, no pixel lost or duplicated.
4. Stall on final row: stall held 5 cycles in LAST -> pix_ready=0 throughout, block_done only in the cycle load_L goes low.
5. Abort after 100 pixels: next edge block_busy=0, no further load_L pulse. A new 225-pixel block then produces row 0 = its first 15 pixels.
6. PIXEL_ROW_PAD_EN: pix_eol at column 9 with value 0xAB -> row_out bytes 9..14 = 0xAB, load_L pulses the next cycle, and the next pixel lands in column 0.
